// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Covers op encodings, FSM state codes and small op-decode helpers.
package mult_div_unit_pkg;

    localparam int MDU_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// One combinational iteration on {acc, q}.
// Multiply: shift-add, LSB of q selects the add. Divide: restoring trial subtract.
module mdu_step #(
    parameter int W = 32
) (
    input  logic         is_div_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] opnd_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] q_o
);

    logic [W:0] sum;
    logic [W:0] rem;
    logic [W:0] trial;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, opnd_i};
        rem   = {acc_i, q_i[W-1]};
        // The running remainder stays below 2*divisor, so bit W of trial is a clean borrow.
        trial = rem - {1'b0, opnd_i};
        acc_o = '0;
        q_o   = '0;
        if (is_div_i) begin
            if (!trial[W]) begin
                acc_o = trial[W-1:0];
                q_o   = {q_i[W-2:0], 1'b1};
            end else begin
                acc_o = rem[W-1:0];
                q_o   = {q_i[W-2:0], 1'b0};
            end
        end else if (q_i[0]) begin
            acc_o = sum[W:1];
            q_o   = {sum[0], q_i[W-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[W-1:1]};
            q_o   = {acc_i[0], q_i[W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One iteration per cycle on unsigned magnitudes; signs are applied on the final edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] Src1,
    input  logic [DATA_WIDTH-1:0] Src2,
    input  logic                  wr_hi,
    input  logic                  wr_lo,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]   acc_q, q_q, opnd_q, hi_q, lo_q;
    logic           is_div_q, neg_lo_q, neg_hi_q;
    logic           done_q, dbz_q, dbz_pend_q;

    logic           accept, dbz_start, last, s1, s2;
    logic [W-1:0]   mag1, mag2, acc_nx, q_nx, hi_res, lo_res;
    logic [2*W-1:0] prod_s;

    assign accept    = (state_q == ST_IDLE) && start;
    assign dbz_start = accept && is_div_op(op) && (Src2 == '0);
    assign last      = (cnt_q == CNT_W'(W));
    assign s1        = is_signed_op(op) & Src1[W-1];
    assign s2        = is_signed_op(op) & Src2[W-1];
    assign mag1      = s1 ? -Src1 : Src1;
    assign mag2      = s2 ? -Src2 : Src2;

    mdu_step #(.W(W)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .q_i      (q_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_nx),
        .q_o      (q_nx)
    );

    always_comb begin
        prod_s = neg_lo_q ? -{acc_q, q_q} : {acc_q, q_q};
        if (is_div_q) begin
            lo_res = neg_lo_q ? -q_q : q_q;
            hi_res = neg_hi_q ? -acc_q : acc_q;
        end else begin
            lo_res = prod_s[W-1:0];
            hi_res = prod_s[2*W-1:W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !dbz_start) state_d = ST_CALC;
            ST_CALC: if (last)                 state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CALC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
        end else begin
            // Divide-by-zero skips iteration but still reports done one edge after accept.
            done_q     <= (state_q == ST_CALC && last) || dbz_pend_q;
            dbz_pend_q <= dbz_start;
            if (accept) begin
                dbz_q    <= dbz_start;
                cnt_q    <= '0;
                is_div_q <= is_div_op(op);
                neg_lo_q <= s1 ^ s2;
                neg_hi_q <= s1;
                acc_q    <= '0;
                q_q      <= is_div_op(op) ? mag1 : mag2;
                opnd_q   <= is_div_op(op) ? mag2 : mag1;
            end else if (state_q == ST_IDLE) begin
                if (wr_hi) hi_q <= Src1;
                if (wr_lo) lo_q <= Src1;
            end else if (!last) begin
                acc_q <= acc_nx;
                q_q   <= q_nx;
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (DATA_WIDTH=32) with an expected-result scoreboard.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] Src1 = '0, Src2 = '0;
    logic        wr_hi = 1'b0, wr_lo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    logic [31:0] mhi = '0, mlo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .Src1(Src1), .Src2(Src2),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic sb_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        sb_t r;
        longint sa, sbv, res;
        logic [63:0] p;
        sa  = $signed(a);
        sbv = $signed(b);
        r.dbz = 1'b0;
        r.hi = mhi;
        r.lo = mlo;
        case (o)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin res = sa * sbv; p = res; r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
                if (b == 0) r.dbz = 1'b1;
                else if (o == 2'b10) begin r.lo = a / b; r.hi = a % b; end
                else begin
                    res = sa / sbv; p = res; r.lo = p[31:0];
                    res = sa % sbv; p = res; r.hi = p[31:0];
                end
            end
        endcase
        return r;
    endfunction

    // Drive one request; returns at the negedge following the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit wait_edge, input bit wl);
        sb_t e;
        if (wait_edge) @(negedge clk);
        start = 1'b1; op = o; Src1 = a; Src2 = b; wr_lo = wl;
        e = model(o, a, b);
        sb.push_back(e);
        mhi = e.hi; mlo = e.lo;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        op = 2'($urandom); Src1 = $urandom; Src2 = $urandom;
    endtask

    task automatic finish_op(input string tag, input int exp_lat, input int exp_busy);
        int n = 0, bc = 0;
        sb_t e;
        if (busy) bc++;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) bc++;
        end
        check({tag, "_lat"}, n, exp_lat);
        if (exp_busy >= 0) check({tag, "_busy"}, bc, exp_busy);
        if (sb.size() == 0) begin
            check({tag, "_sb"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_hi"}, HI, e.hi);
            check({tag, "_lo"}, LO, e.lo);
            check({tag, "_dbz"}, div_by_zero, e.dbz);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);

        issue(2'b01, 32'hFFFFFFFD, 32'h5, 1, 0);
        finish_op("mult_neg", 33, -1);
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        finish_op("multu_max", 33, 33);
        issue(2'b11, 32'hFFFFFFF9, 32'h2, 1, 0);
        finish_op("div_neg", 33, -1);
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 1, 0);
        finish_op("div_min", 33, -1);

        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; Src1 = 32'hCAFE;
        @(negedge clk);
        wr_lo = 1'b0; Src1 = 32'h1234;
        check("mt_both_lo", LO, 32'hCAFE);
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; Src1 = 32'h5678;
        @(negedge clk);
        wr_lo = 1'b0;
        check("mthi", HI, 32'h1234);
        check("mtlo", LO, 32'h5678);
        mhi = 32'h1234; mlo = 32'h5678;

        // Divide by zero with a concurrent MTLO: start wins, LO stays.
        issue(2'b10, 32'h100, 32'h0, 0, 1);
        finish_op("divu_zero", 1, 0);
        repeat (3) @(negedge clk);
        check("dbz_hold", div_by_zero, 1);
        check("dbz_done_pulse", done, 0);

        // Start and MTHI pulsed mid-operation must be ignored.
        issue(2'b01, 32'h7FFF0001, 32'hFFFF8000, 1, 0);
        check("dbz_clear", div_by_zero, 0);
        repeat (10) @(negedge clk);
        start = 1'b1; op = 2'b10; Src2 = 32'h0; wr_hi = 1'b1; Src1 = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        finish_op("mid_ignore", 22, -1);

        // Back-to-back: start in the done cycle.
        issue(2'b10, 32'h100, 32'h7, 0, 0);
        finish_op("b2b", 33, 33);
        @(negedge clk);
        check("b2b_idle_busy", busy, 0);
        check("b2b_idle_done", done, 0);

        for (int i = 0; i < 6; i++) begin
            issue(2'(i), $urandom, $urandom | 32'h1, 1, 0);
            finish_op("rand", 33, 33);
        end

        // Asynchronous reset mid-operation.
        issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 1, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int dc = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done === 1'b1) dc++;
            end
            check("arst_no_done", dc, 0);
        end
        check("arst_hi_after", HI, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
